// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer in front of a single-port synchronous RAM.
// Requesters A and B share one RAM command port. Accesses are serialised and
// read data comes back with a one-cycle valid pulse.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: A always wins ties (B may starve).
// Without it, ties alternate round-robin.
module ram_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          ram_write,
  output logic          ram_read,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_e;

  state_e        state_q, state_d;
  logic          sel_b_q, sel_b_d;     // latched command belongs to B
  logic          we_q, we_d;           // latched command is a write
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic          last_b_q, last_b_d;   // last grant went to B
`endif
  logic          pick_a, pick_b;
  logic          sel_we;

  logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic          ram_write_q, ram_write_d, ram_read_q, ram_read_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          busy_q, busy_d;

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_b_q     <= 1'b0;
      we_q        <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_b_q    <= 1'b1;
`endif
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_b_q     <= sel_b_d;
      we_q        <= we_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_b_q    <= last_b_d;
`endif
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      ram_write_q <= ram_write_d;
      ram_read_q  <= ram_read_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Arbitration, next state, and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    sel_b_d     = sel_b_q;
    we_d        = we_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_b_d    = last_b_q;
`endif
    pick_a      = 1'b0;
    pick_b      = 1'b0;
    sel_we      = 1'b0;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rvalid_a_d  = 1'b0;
    rvalid_b_d  = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    ram_write_d = 1'b0;
    ram_read_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      IDLE: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        pick_a = req_a;
        pick_b = req_b & ~req_a;
`else
        if (req_a && req_b) begin
          pick_a = last_b_q;
          pick_b = ~last_b_q;
        end else begin
          pick_a = req_a;
          pick_b = req_b;
        end
`endif
        sel_we = pick_b ? we_b : we_a;
        if (pick_a || pick_b) begin
          // Outputs for the ISSUE cycle are loaded straight from the winner.
          state_d     = ISSUE;
          sel_b_d     = pick_b;
          we_d        = sel_we;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_b_d    = pick_b;
`endif
          gnt_a_d     = pick_a;
          gnt_b_d     = pick_b;
          ram_write_d = sel_we;
          ram_read_d  = ~sel_we;
          ram_addr_d  = pick_b ? addr_b : addr_a;
          ram_wdata_d = pick_b ? wdata_b : wdata_a;
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : CAPT;
      end
      CAPT: begin
        // RAM read data is valid now; hand it to the owner next cycle.
        state_d = IDLE;
        if (sel_b_q) begin
          rdata_b_d  = ram_rdata;
          rvalid_b_d = 1'b1;
        end else begin
          rdata_a_d  = ram_rdata;
          rvalid_a_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign ram_write = ram_write_q;
  assign ram_read  = ram_read_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x16 synchronous RAM
// preloaded with mem[i] = 3*i + 7. Outputs are sampled on the falling edge.
module tb_ram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ram_write, ram_read;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM; preload happens on the first edge (inside reset).
  logic [DW-1:0] mem [64];
  logic          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(3 * i + 7);
      preloaded <= 1'b1;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_read)  ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt_a"}, 32'(gnt_a), 0);
    chk({tag, ".gnt_b"}, 32'(gnt_b), 0);
    chk({tag, ".rvalid_a"}, 32'(rvalid_a), 0);
    chk({tag, ".rvalid_b"}, 32'(rvalid_b), 0);
    chk({tag, ".rdata_a"}, 32'(rdata_a), 0);
    chk({tag, ".rdata_b"}, 32'(rdata_b), 0);
    chk({tag, ".ram_write"}, 32'(ram_write), 0);
    chk({tag, ".ram_read"}, 32'(ram_read), 0);
    chk({tag, ".ram_addr"}, 32'(ram_addr), 0);
    chk({tag, ".ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // A read addr 5: gnt c1, rvalid c3, rdata 22, busy c1-c2
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd5;
    tick();
    chk("rd5.gnt_a", 32'(gnt_a), 1);
    chk("rd5.gnt_b", 32'(gnt_b), 0);
    chk("rd5.busy1", 32'(busy), 1);
    chk("rd5.ram_read", 32'(ram_read), 1);
    chk("rd5.ram_write", 32'(ram_write), 0);
    chk("rd5.ram_addr", 32'(ram_addr), 5);
    req_a = 1'b0;
    tick();
    chk("rd5.gnt_a_c2", 32'(gnt_a), 0);
    chk("rd5.busy2", 32'(busy), 1);
    chk("rd5.ram_read_c2", 32'(ram_read), 0);
    chk("rd5.rvalid_c2", 32'(rvalid_a), 0);
    tick();
    chk("rd5.rvalid_a", 32'(rvalid_a), 1);
    chk("rd5.rdata_a", 32'(rdata_a), 22);
    chk("rd5.busy3", 32'(busy), 0);
    tick();
    chk("rd5.rvalid_a_c4", 32'(rvalid_a), 0);
    chk("rd5.rdata_hold", 32'(rdata_a), 22);

    // B write addr 10 = BEEF, then A reads it back
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'd10; wdata_b = 16'hBEEF;
    tick();
    chk("wrb.gnt_b", 32'(gnt_b), 1);
    chk("wrb.gnt_a", 32'(gnt_a), 0);
    chk("wrb.ram_write", 32'(ram_write), 1);
    chk("wrb.ram_read", 32'(ram_read), 0);
    chk("wrb.ram_addr", 32'(ram_addr), 10);
    chk("wrb.ram_wdata", 32'(ram_wdata), 32'hBEEF);
    req_b = 1'b0;
    tick();
    chk("wrb.gnt_b_c2", 32'(gnt_b), 0);
    chk("wrb.busy_c2", 32'(busy), 0);
    chk("wrb.ram_write_c2", 32'(ram_write), 0);
    chk("wrb.addr_hold", 32'(ram_addr), 10);
    chk("wrb.rvalid_b", 32'(rvalid_b), 0);
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd10;
    tick();
    chk("rd10.gnt_a", 32'(gnt_a), 1);
    req_a = 1'b0;
    tick();
    chk("rd10.rvalid_b", 32'(rvalid_b), 0);
    tick();
    chk("rd10.rvalid_a", 32'(rvalid_a), 1);
    chk("rd10.rdata_a", 32'(rdata_a), 32'hBEEF);
    chk("rd10.rvalid_b_c3", 32'(rvalid_b), 0);

    // Both requesting reads from reset, held: grants A,B,A,B every 3 cycles
    rst_n = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd2;
    tick();
    rst_n = 1'b1;
    tick();   // c1
    chk("rr.c1.gnt_a", 32'(gnt_a), 1);
    chk("rr.c1.gnt_b", 32'(gnt_b), 0);
    tick(); tick();   // c3
    chk("rr.c3.rvalid_a", 32'(rvalid_a), 1);
    chk("rr.c3.rdata_a", 32'(rdata_a), 10);
    chk("rr.c3.rvalid_b", 32'(rvalid_b), 0);
    tick();   // c4
    chk("rr.c4.gnt_b", 32'(gnt_b), 1);
    chk("rr.c4.gnt_a", 32'(gnt_a), 0);
    chk("rr.c4.ram_addr", 32'(ram_addr), 2);
    tick(); tick();   // c6
    chk("rr.c6.rvalid_b", 32'(rvalid_b), 1);
    chk("rr.c6.rdata_b", 32'(rdata_b), 13);
    tick();   // c7
`ifdef RAM_ARB_FIXED_PRIO_EN
    chk("rr.c7.gnt_a", 32'(gnt_a), 1);
`else
    chk("rr.c7.gnt_a", 32'(gnt_a), 1);
    chk("rr.c7.gnt_b", 32'(gnt_b), 0);
    tick(); tick(); tick();   // c10
    chk("rr.c10.gnt_b", 32'(gnt_b), 1);
    chk("rr.c10.gnt_a", 32'(gnt_a), 0);
`endif
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick(); tick();

    // Reset during ISSUE of an A read: everything clears, no late rvalid
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd3;
    tick();
    chk("rst.gnt_a_before", 32'(gnt_a), 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst.async");
    req_a = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.no_rvalid", 32'(rvalid_a), 0);
      chk("rst.idle", 32'(busy), 0);
    end

    // Back-to-back A writes addr 0..3, req held: gnt every 2 cycles
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd0; wdata_a = 16'h1000;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr.gnt_a", 32'(gnt_a), 1);
      chk("wr.ram_write", 32'(ram_write), 1);
      chk("wr.ram_addr", 32'(ram_addr), 32'(i));
      chk("wr.ram_wdata", 32'(ram_wdata), 32'h1000 + 32'(i));
      if (i < 3) begin
        addr_a = 6'(i + 1); wdata_a = 16'(16'h1000 + i + 1);
      end else begin
        req_a = 1'b0;
      end
      tick();
      chk("wr.gap_gnt_a", 32'(gnt_a), 0);
      chk("wr.gap_busy", 32'(busy), 0);
      tick();
    end
    chk("wr.after_gnt_a", 32'(gnt_a), 0);
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1; we_a = 1'b0; addr_a = 6'(i);
      tick();
      req_a = 1'b0;
      tick(); tick();
      chk("rb.rvalid_a", 32'(rvalid_a), 1);
      chk("rb.rdata_a", 32'(rdata_a), 32'h1000 + 32'(i));
      tick();
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: A held starves B; dropping A lets B through
    begin
      int seen;
      req_a = 1'b1; we_a = 1'b0; addr_a = 6'd1;
      req_b = 1'b1; we_b = 1'b0; addr_b = 6'd2;
      for (int i = 0; i < 9; i++) begin
        tick();
        chk("fp.no_gnt_b", 32'(gnt_b), 0);
      end
      req_a = 1'b0;
      seen = 0;
      for (int i = 0; i < 6 && seen == 0; i++) begin
        tick();
        if (gnt_b) seen = 1;
      end
      chk("fp.gnt_b_after_drop", 32'(seen), 1);
      req_b = 1'b0;
      tick(); tick(); tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
